// File: rtl/countdown_timer5_pkg.sv
// countdown_timer5_pkg: shared state encoding and default sizing for move timers
package countdown_timer5_pkg;
   localparam int DEF_WIDTH = 5;
   localparam int DEF_PRESCALE = 4;
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PAUSE   = 2'd2,
      ST_EXPIRED = 2'd3
   } state_e;
endpackage

// File: rtl/countdown_timer5_prescaler_tick.sv
// countdown_timer5_prescaler_tick: modulo-PRESCALE enabled counter with terminal tick
module countdown_timer5_prescaler_tick #(
   parameter int PRESCALE = 4
) (
   input  logic clock,
   input  logic clr,
   input  logic clear,
   input  logic en,
   output logic tick
);
   localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
   logic [PW-1:0] cnt_q, cnt_d;
   assign tick = en && (cnt_q == LAST);
   always_comb cnt_d = clear ? '0 : !en ? cnt_q : tick ? '0 : cnt_q + PW'(1);
   always_ff @(posedge clock)
      if (!clr) cnt_q <= '0;
      else cnt_q <= cnt_d;
endmodule

// File: rtl/countdown_timer5.sv
// countdown_timer5: loadable prescaled down counter that flags expiry once and never wraps
module countdown_timer5
   import countdown_timer5_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int PRESCALE = DEF_PRESCALE
) (
   input  logic             clock,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             enable,
   output logic [WIDTH-1:0] out,
   output logic             zero,
   output logic             running,
   output logic             done,
   output logic [1:0]       state
);
   state_e state_q, state_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic done_q, done_d, running_q, running_d;
   logic active, tick, last;
   // RUN and PAUSE always hold a nonzero count, so this covers IDLE/RUN/PAUSE alike
   assign active = enable && (out_q != '0) && (state_q != ST_EXPIRED);
   assign last = tick && (out_q == WIDTH'(1));
   countdown_timer5_prescaler_tick #(.PRESCALE(PRESCALE)) u_prescaler_tick (
      .clock(clock),
      .clr(clr),
      .clear(load),
      .en(active),
      .tick(tick)
   );
   always_comb begin
      out_d = load ? load_val : tick ? out_q - WIDTH'(1) : out_q;
      done_d = !load && last;
      state_d = load ? ST_IDLE : last ? ST_EXPIRED : active ? ST_RUN :
                (state_q == ST_RUN) ? ST_PAUSE : state_q;
      running_d = (state_d == ST_RUN);
   end
   always_ff @(posedge clock)
      if (!clr) begin
         state_q <= ST_IDLE;
         out_q <= '0;
         done_q <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q <= out_d;
         done_q <= done_d;
         running_q <= running_d;
      end
   assign out = out_q;
   assign zero = (out_q == '0);
   assign running = running_q;
   assign done = done_q;
   assign state = state_q;
endmodule

// File: tb/tb_countdown_timer5.sv
// tb_countdown_timer5: scoreboard bench checking countdown, pause, load priority and reset
module tb_countdown_timer5;
   logic clock, clr, load, enable;
   logic [4:0] load_val, out;
   logic zero, running, done;
   logic [1:0] state;
   logic [9:0] got, x;
   logic [9:0] sb[$];
   int errors = 0;
   int checks = 0;

   countdown_timer5 dut (
      .clock(clock),
      .clr(clr),
      .load(load),
      .load_val(load_val),
      .enable(enable),
      .out(out),
      .zero(zero),
      .running(running),
      .done(done),
      .state(state)
   );

   always #5 clock = ~clock;
   assign got = {out, zero, running, done, state};

   function automatic logic [9:0] mk(input int o, input int s, input logic d);
      logic [4:0] ov;
      logic [1:0] sv;
      ov = 5'(o);
      sv = 2'(s);
      return {ov, ov == 5'd0, sv == 2'd1, d, sv};
   endfunction

   task automatic drive(input logic c, input logic l, input int lv, input logic e, input logic [9:0] xp);
      @(negedge clock);
      clr = c;
      load = l;
      load_val = 5'(lv);
      enable = e;
      sb.push_back(xp);
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset;
      for (int i = 0; i < 2; i++) begin
         drive(0, i == 0, 9, 1, mk(0, 0, 0));
         x = sb.pop_front();
         if (got !== x) begin errors++; $display("FAIL reset[%0d] got=%h expected=%h", i, got, x); end
         checks++;
      end
   endtask

   task automatic test_countdown;
      for (int i = 0; i <= 22; i++) begin
         if (i == 0) drive(1, 1, 3, 0, mk(3, 0, 0));
         else if (i < 12) drive(1, 0, 0, 1, mk(3 - i / 4, 1, 0));
         else drive(1, 0, 0, 1, mk(0, 3, i == 12));
         x = sb.pop_front();
         if (got !== x) begin errors++; $display("FAIL countdown[%0d] got=%h expected=%h", i, got, x); end
         checks++;
      end
   endtask

   task automatic test_pause;
      for (int i = 0; i <= 13; i++) begin
         if (i == 0) drive(1, 1, 2, 0, mk(2, 0, 0));
         else if (i <= 2) drive(1, 0, 0, 1, mk(2, 1, 0));
         else if (i <= 7) drive(1, 0, 0, 0, mk(2, 2, 0));
         else if (i < 13) drive(1, 0, 0, 1, mk(2 - (i - 5) / 4, 1, 0));
         else drive(1, 0, 0, 1, mk(0, 3, 1));
         x = sb.pop_front();
         if (got !== x) begin errors++; $display("FAIL pause[%0d] got=%h expected=%h", i, got, x); end
         checks++;
      end
   endtask

   task automatic test_collision;
      for (int i = 0; i <= 8; i++) begin
         if (i == 0) drive(1, 1, 1, 0, mk(1, 0, 0));
         else if (i <= 3) drive(1, 0, 0, 1, mk(1, 1, 0));
         else if (i == 4) drive(1, 1, 7, 1, mk(7, 0, 0));
         else if (i <= 7) drive(1, 0, 0, 1, mk(7, 1, 0));
         else drive(1, 0, 0, 1, mk(6, 1, 0));
         x = sb.pop_front();
         if (got !== x) begin errors++; $display("FAIL collision[%0d] got=%h expected=%h", i, got, x); end
         checks++;
      end
   endtask

   task automatic test_zero_reload;
      for (int i = 0; i <= 138; i++) begin
         if (i == 0) drive(1, 1, 0, 0, mk(0, 0, 0));
         else if (i <= 6) drive(1, 0, 0, 1, mk(0, 0, 0));
         else if (i == 7) drive(1, 1, 1, 0, mk(1, 0, 0));
         else if (i <= 10) drive(1, 0, 0, 1, mk(1, 1, 0));
         else if (i == 11) drive(1, 0, 0, 1, mk(0, 3, 1));
         else if (i == 12) drive(1, 1, 31, 1, mk(31, 0, 0));
         else if (i < 136) drive(1, 0, 0, 1, mk(31 - (i - 12) / 4, 1, 0));
         else drive(1, 0, 0, 1, mk(0, 3, i == 136));
         x = sb.pop_front();
         if (got !== x) begin errors++; $display("FAIL zero_reload[%0d] got=%h expected=%h", i, got, x); end
         checks++;
      end
   endtask

   task automatic test_midrun_reset;
      for (int i = 0; i <= 7; i++) begin
         if (i == 0) drive(1, 1, 6, 0, mk(6, 0, 0));
         else if (i <= 3) drive(1, 0, 0, 1, mk(6, 1, 0));
         else if (i == 4) drive(1, 0, 0, 1, mk(5, 1, 0));
         else if (i == 5) drive(0, 0, 0, 1, mk(0, 0, 0));
         else if (i == 6) drive(1, 0, 0, 1, mk(0, 0, 0));
         else drive(1, 1, 2, 1, mk(2, 0, 0));
         x = sb.pop_front();
         if (got !== x) begin errors++; $display("FAIL midrun_reset[%0d] got=%h expected=%h", i, got, x); end
         checks++;
      end
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i <= 5; i++) begin
         if (i == 0) drive(1, 1, 9, 0, mk(9, 0, 0));
         else if (i == 1) drive(1, 1, 4, 1, mk(4, 0, 0));
         else if (i < 5) drive(1, 0, 0, 1, mk(4, 1, 0));
         else drive(1, 0, 0, 1, mk(3, 1, 0));
         x = sb.pop_front();
         if (got !== x) begin errors++; $display("FAIL back_to_back[%0d] got=%h expected=%h", i, got, x); end
         checks++;
      end
   endtask

   initial begin
      clock = 0;
      clr = 0;
      load = 0;
      load_val = 0;
      enable = 0;
      test_reset;
      test_countdown;
      test_pause;
      test_collision;
      test_zero_reload;
      test_midrun_reset;
      test_back_to_back;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/countdown_timer5.md
Name: countdown_timer5

Overview:
- Loadable synchronous down counter with prescaler and terminal-count detection. It is the count-down counterpart of the team's ripple up counter.
- Serves as the per-player move timer in the chess datapath:
  - the controller loads a time budget;
  - the timer decrements while enabled;
  - the timer flags expiry exactly once when it reaches zero.
- It never wraps below zero.

Parameters:
WIDTH, 5, width of count value and load value
PRESCALE, 4, number of enabled clock cycles per decrement (must be >= 1)

Ports:
clock  in  1  sole clock; all state updates on its rising edge
clr  in  1  reset: synchronous, active-low, sampled on rising edge of clock
load  in  1  load load_val into the counter this cycle
load_val  in  WIDTH  value to load
enable  in  1  count when high; pause when low
out  out  WIDTH  current remaining count
zero  out  1  high whenever out == 0
running  out  1  high in RUN state
done  out  1  single-cycle pulse on the cycle out becomes 0 by decrement
state  out  2  IDLE=0, RUN=1, PAUSE=2, EXPIRED=3 (debug/controller visibility)

Behaviour:
- Priority per rising edge: clr low > load > count logic.
- Reset (clr==0): out=0, prescaler=0, state=IDLE, done=0, running=0. zero is combinational, so zero=1 after reset.
- Load (clr==1, load==1):
  - out<=load_val, prescaler<=0, state<=IDLE, done<=0, regardless of current state.
  - Load wins over a simultaneous decrement.
  - Load is accepted mid-RUN, PAUSE, or EXPIRED.
- IDLE:
  - enable==1 and out!=0 -> RUN. The prescaler counts from this same cycle, so the enable cycle is enabled cycle #1.
  - out==0 -> stay IDLE. No done pulse for a zero load.
- RUN:
  - enable==1: prescaler increments.
  - When prescaler==PRESCALE-1: prescaler<=0, out<=out-1.
  - enable==0: -> PAUSE; prescaler and out hold.
- PAUSE:
  - enable==1 -> RUN, resuming the prescaler from its held value. That cycle counts as an enabled cycle.
  - Otherwise hold.
- Decrement from 1 to 0: same edge sets state<=EXPIRED and done<=1.
  - done is registered: high for exactly one cycle, the cycle in which out first reads 0.
  - done is low in every other cycle.
- EXPIRED:
  - out held at 0; enable ignored; no wrap to 2^WIDTH-1.
  - Leave only by load or clr.
- Latency: with enable held high from IDLE, out falls by 1 on the PRESCALE-th rising edge. A full budget N expires after N*PRESCALE enabled edges.
- PRESCALE==1: decrement on every enabled edge; prescaler logic degenerates but must still synthesize.
- Max load (2^WIDTH-1 = 31 at default) counts down to 0 with no overflow.
- running is a registered decode of state==RUN.
- zero is combinational from out.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE/RUN/PAUSE/EXPIRED, 2 bits);
  - default WIDTH/PRESCALE values for reuse by the chess clock controller.
- One natural sub-module: prescaler_tick, a PRESCALE-modulo counter with enable, clear and a terminal-tick output. The FSM and down-count register stay in countdown_timer5.

Test Plan:
- Reset: clr=0 for 2 cycles with load/enable toggling -> out=0, zero=1, state=0, done=0, running=0.
- Basic countdown, PRESCALE=4:
  - stimulus: load 3, then enable held high;
  - out 3->2 at the 4th enabled edge, ->1 at the 8th, ->0 at the 12th;
  - done=1 for exactly one cycle with out=0; state=3;
  - out stays 0 for 10 further cycles.
- Pause/resume:
  - stimulus: load 2, enable 2 cycles, drop enable 5 cycles, re-enable;
  - state=2 during the pause; out holds 2;
  - first decrement after 2 more enabled edges (4 total).
- Load collision:
  - stimulus: load=1 with load_val=7 on the same edge the prescaler terminal decrement would fire;
  - out=7, prescaler=0, state=0, no done pulse.
- Zero load and reload from EXPIRED:
  - load 0, enable 6 cycles -> state stays 0, done never asserts;
  - from EXPIRED, load 31 -> out=31, state=0; reaching 0 takes 124 enabled edges.
- Mid-run reset: clr=0 during RUN with out=5 -> next cycle out=0, state=0, done=0, enable ignored that edge.
